// File: rtl/al_cdac.sv
// al_cdac: serial loader for the comparator-threshold DAC.
// Latches {DAC_CTRL, BPI_AL_REG} on a CAPTURE rising edge and shifts the
// 16-bit frame out MSB-first, changing SDATA just after each CLK1MHZ falling
// edge so the DAC samples on CLK1MHZ rising edges. DONE is sticky until
// CLR_AL_DONE. CLK1MHZ is sampled as data in the CLK40 domain.
module al_cdac #(
  parameter logic [3:0] DAC_CTRL = 4'hC,
  parameter int         NBITS    = 16
) (
  input  logic        CLK40,
  input  logic        RST,
  input  logic        CLK1MHZ,
  input  logic        CLR_AL_DONE,
  input  logic        CAPTURE,
  input  logic [11:0] BPI_AL_REG,
  output logic        SHCK_ENA,
  output logic        SDATA,
  output logic        DAC_ENB,
  output logic        DONE
);

  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic             c1m_meta_r;
  logic             c1m_sync_r;
  logic             c1m_d_r;
  logic             cap_d_r;
  logic             fall_tick_s;
  logic             cap_rise_s;

  logic [NBITS-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic             shck_ena_r;
  logic             sdata_r;
  logic             dac_enb_r;
  logic             done_r;

  logic [NBITS-1:0] shreg_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             shck_ena_nxt_s;
  logic             sdata_nxt_s;
  logic             dac_enb_nxt_s;
  logic             done_set_s;
  logic             last_bit_s;

  assign fall_tick_s = c1m_d_r & ~c1m_sync_r;
  assign cap_rise_s  = CAPTURE & ~cap_d_r;
  assign last_bit_s  = (cnt_r == CW'(NBITS - 1));

  // Two-flop synchronizer for CLK1MHZ plus edge-detect history flops.
  always_ff @(posedge CLK40) begin
    if (!RST) begin
      c1m_meta_r <= 1'b0;
      c1m_sync_r <= 1'b0;
      c1m_d_r    <= 1'b0;
      cap_d_r    <= 1'b0;
    end else begin
      c1m_meta_r <= CLK1MHZ;
      c1m_sync_r <= c1m_meta_r;
      c1m_d_r    <= c1m_sync_r;
      cap_d_r    <= CAPTURE;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK40) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic: capture, wait for first tick, shift NBITS ticks.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cap_rise_s) begin
          state_nxt_s = ST_SYNC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (fall_tick_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_SYNC;
        end
      end
      ST_SHIFT: begin
        if (fall_tick_s && last_bit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: next values of the registered pins and datapath.
  always_comb begin
    shreg_nxt_s    = shreg_r;
    cnt_nxt_s      = cnt_r;
    shck_ena_nxt_s = shck_ena_r;
    sdata_nxt_s    = sdata_r;
    dac_enb_nxt_s  = dac_enb_r;
    done_set_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        shck_ena_nxt_s = 1'b0;
        sdata_nxt_s    = 1'b0;
        dac_enb_nxt_s  = 1'b1;
        if (cap_rise_s) begin
          shreg_nxt_s = {DAC_CTRL, BPI_AL_REG};
        end else begin
          shreg_nxt_s = shreg_r;
        end
      end
      ST_SYNC: begin
        if (fall_tick_s) begin
          dac_enb_nxt_s  = 1'b0;
          shck_ena_nxt_s = 1'b1;
          sdata_nxt_s    = shreg_r[NBITS-1];
          cnt_nxt_s      = {CW{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_SHIFT: begin
        if (fall_tick_s && last_bit_s) begin
          shck_ena_nxt_s = 1'b0;
          sdata_nxt_s    = 1'b0;
          dac_enb_nxt_s  = 1'b1;
          done_set_s     = 1'b1;
        end else if (fall_tick_s) begin
          shreg_nxt_s = {shreg_r[NBITS-2:0], 1'b0};
          sdata_nxt_s = shreg_r[NBITS-2];
          cnt_nxt_s   = cnt_r + CW'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        shck_ena_nxt_s = 1'b0;
        sdata_nxt_s    = 1'b0;
        dac_enb_nxt_s  = 1'b1;
      end
    endcase
  end

  // Datapath and pin registers; reset aborts any frame in progress.
  always_ff @(posedge CLK40) begin
    if (!RST) begin
      shreg_r    <= {NBITS{1'b0}};
      cnt_r      <= {CW{1'b0}};
      shck_ena_r <= 1'b0;
      sdata_r    <= 1'b0;
      dac_enb_r  <= 1'b1;
    end else begin
      shreg_r    <= shreg_nxt_s;
      cnt_r      <= cnt_nxt_s;
      shck_ena_r <= shck_ena_nxt_s;
      sdata_r    <= sdata_nxt_s;
      dac_enb_r  <= dac_enb_nxt_s;
    end
  end

  // Sticky DONE flag; setting on the last tick beats a simultaneous clear.
  always_ff @(posedge CLK40) begin
    if (!RST) begin
      done_r <= 1'b0;
    end else if (done_set_s) begin
      done_r <= 1'b1;
    end else if (CLR_AL_DONE) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_r;
    end
  end

  assign SHCK_ENA = shck_ena_r;
  assign SDATA    = sdata_r;
  assign DAC_ENB  = dac_enb_r;
  assign DONE     = done_r;

endmodule

// File: tb/tb_al_cdac.sv
// Directed bench for al_cdac: frames are captured on CLK1MHZ rising edges
// while SHCK_ENA is high and compared with hand-computed 16-bit words.
`timescale 1ns/1ps
module tb_al_cdac;

  logic        CLK40 = 1'b0;
  logic        RST = 1'b0;
  logic        CLK1MHZ = 1'b0;
  logic        CLR_AL_DONE = 1'b0;
  logic        CAPTURE = 1'b0;
  logic [11:0] BPI_AL_REG = 12'h000;
  logic        SHCK_ENA;
  logic        SDATA;
  logic        DAC_ENB;
  logic        DONE;

  int checks = 0;
  int failures = 0;

  // Frame monitor state
  int          mon_bits = 0;
  int          mon_unstable = 0;
  logic [15:0] mon_frame = 16'h0000;

  al_cdac dut (
    .CLK40       (CLK40),
    .RST         (RST),
    .CLK1MHZ     (CLK1MHZ),
    .CLR_AL_DONE (CLR_AL_DONE),
    .CAPTURE     (CAPTURE),
    .BPI_AL_REG  (BPI_AL_REG),
    .SHCK_ENA    (SHCK_ENA),
    .SDATA       (SDATA),
    .DAC_ENB     (DAC_ENB),
    .DONE        (DONE)
  );

  always #12.5 CLK40 = ~CLK40;
  always #500  CLK1MHZ = ~CLK1MHZ;

  // DAC-side view: shift SDATA in on each gated SCLK rise, then make sure
  // the bit has not moved shortly after the edge.
  always @(posedge CLK1MHZ) begin
    logic v;
    if (SHCK_ENA === 1'b1) begin
      v = SDATA;
      mon_frame = {mon_frame[14:0], v};
      mon_bits = mon_bits + 1;
      #100;
      if (SDATA !== v) mon_unstable = mon_unstable + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK40);
  endtask

  task automatic wait_enb(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (DAC_ENB !== lvl && n < budget) begin
      @(negedge CLK40);
      n = n + 1;
    end
    check(tag, {31'd0, DAC_ENB}, {31'd0, lvl});
  endtask

  task automatic start_load(input logic [11:0] v);
    BPI_AL_REG = v;
    CAPTURE = 1'b1;
    step(1);
    CAPTURE = 1'b0;
  endtask

  task automatic clear_done();
    CLR_AL_DONE = 1'b1;
    step(1);
    CLR_AL_DONE = 1'b0;
  endtask

  task automatic idle_activity(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (DAC_ENB !== 1'b1 || SHCK_ENA !== 1'b0 || SDATA !== 1'b0) bad = bad + 1;
    end
  endtask

  initial begin
    int base;
    int bad;
    int n;

    // Reset
    RST = 1'b0;
    step(5);
    check("rst_enb",  {31'd0, DAC_ENB},  32'd1);
    check("rst_shck", {31'd0, SHCK_ENA}, 32'd0);
    check("rst_sdata",{31'd0, SDATA},    32'd0);
    check("rst_done", {31'd0, DONE},     32'd0);
    idle_activity(80, bad);
    check("rst_quiet", bad, 32'd0);
    RST = 1'b1;
    idle_activity(100, bad);
    check("idle_quiet", bad, 32'd0);
    check("idle_nobits", mon_bits, 32'd0);

    // Basic load 001 -> C001
    base = mon_bits;
    start_load(12'h001);
    wait_enb(1'b0, 200, "basic_enb_fall");
    check("basic_fall_after_c1m_fall", {31'd0, CLK1MHZ}, 32'd0);
    check("basic_shck_on", {31'd0, SHCK_ENA}, 32'd1);
    wait_enb(1'b1, 1000, "basic_enb_rise");
    check("basic_frame", {16'd0, mon_frame}, 32'h0000C001);
    check("basic_nbits", mon_bits - base, 32'd16);
    check("basic_done", {31'd0, DONE}, 32'd1);
    check("basic_shck_off", {31'd0, SHCK_ENA}, 32'd0);
    check("basic_sdata_off", {31'd0, SDATA}, 32'd0);

    // DONE clear by single-cycle pulse
    clear_done();
    check("clr_done", {31'd0, DONE}, 32'd0);

    // DONE set wins over a CLR held through the final tick
    CLR_AL_DONE = 1'b1;
    start_load(12'h0F0);
    wait_enb(1'b0, 200, "clrheld_enb_fall");
    wait_enb(1'b1, 1000, "clrheld_enb_rise");
    check("clrheld_done_set", {31'd0, DONE}, 32'd1);
    check("clrheld_frame", {16'd0, mon_frame}, 32'h0000C0F0);
    step(1);
    check("clrheld_done_next", {31'd0, DONE}, 32'd0);
    CLR_AL_DONE = 1'b0;

    // Busy: second CAPTURE and BPI change mid-frame are ignored
    base = mon_bits;
    start_load(12'h3C3);
    wait_enb(1'b0, 200, "busy_enb_fall");
    step(200);
    start_load(12'hFFF);
    wait_enb(1'b1, 1000, "busy_enb_rise");
    check("busy_frame", {16'd0, mon_frame}, 32'h0000C3C3);
    check("busy_nbits", mon_bits - base, 32'd16);
    idle_activity(200, bad);
    check("busy_not_queued", bad, 32'd0);
    check("busy_nbits_after", mon_bits - base, 32'd16);

    // CAPTURE held high 100 cycles -> one frame
    base = mon_bits;
    BPI_AL_REG = 12'h123;
    CAPTURE = 1'b1;
    step(100);
    CAPTURE = 1'b0;
    wait_enb(1'b1, 1000, "hold_enb_rise");
    check("hold_frame", {16'd0, mon_frame}, 32'h0000C123);
    idle_activity(200, bad);
    check("hold_quiet", bad, 32'd0);
    check("hold_nbits", mon_bits - base, 32'd16);

    // Reset mid-frame (DONE is still set from the previous loads)
    check("midrst_done_pre", {31'd0, DONE}, 32'd1);
    base = mon_bits;
    start_load(12'h7E1);
    n = 0;
    while (mon_bits - base < 5 && n < 1000) begin
      step(1);
      n = n + 1;
    end
    check("midrst_reach_bit5", mon_bits - base, 32'd5);
    RST = 1'b0;
    step(1);
    check("midrst_enb",  {31'd0, DAC_ENB},  32'd1);
    check("midrst_shck", {31'd0, SHCK_ENA}, 32'd0);
    check("midrst_done", {31'd0, DONE},     32'd0);
    RST = 1'b1;
    idle_activity(100, bad);
    check("midrst_quiet", bad, 32'd0);
    check("midrst_nbits", mon_bits - base, 32'd5);
    check("midrst_no_done", {31'd0, DONE}, 32'd0);
    base = mon_bits;
    start_load(12'hA5C);
    wait_enb(1'b0, 200, "postrst_enb_fall");
    wait_enb(1'b1, 1000, "postrst_enb_rise");
    check("postrst_frame", {16'd0, mon_frame}, 32'h0000CA5C);
    check("postrst_nbits", mon_bits - base, 32'd16);
    check("postrst_done", {31'd0, DONE}, 32'd1);

    // Alternating pattern
    base = mon_bits;
    start_load(12'h555);
    wait_enb(1'b0, 200, "pat_enb_fall");
    wait_enb(1'b1, 1000, "pat_enb_rise");
    check("pat_frame", {16'd0, mon_frame}, 32'h0000C555);
    check("pat_nbits", mon_bits - base, 32'd16);
    step(10);
    check("sdata_stable", mon_unstable, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
